// File: rtl/path_lock_arbiter.sv
// Path-position lock arbiter: requesters latch a position mask, wait until it does
// not conflict with held positions, and are granted one at a time in round-robin order.
module path_lock_arbiter #(
  parameter int NREQ = 4,
  parameter int NPOS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*NPOS-1:0] req_mask,
  input  logic [NREQ-1:0]      rel,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      held,
  output logic [NPOS-1:0]      lock_map,
  output logic [31:0]          stall_cnt
);

  localparam int          RRW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREQ_U = NREQ;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HELD} st_t;

  st_t             state [NREQ];
  logic [NPOS-1:0] mask  [NREQ];
  logic [RRW-1:0]  rr;

  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] gnt_vec;
  logic            gnt_vld;
  logic [RRW-1:0]  gnt_idx;
  logic [RRW-1:0]  rr_next;
  logic            any_wait;
  logic [NPOS-1:0] lock_next;

  // A waiter is eligible only if still requesting and clear of the pre-edge lock_map.
  always_comb begin
    cand     = '0;
    any_wait = 1'b0;
    for (int unsigned r = 0; r < NREQ_U; r++) begin
      held[r] = (state[r] == ST_HELD);
      if (state[r] == ST_WAIT) begin
        any_wait = 1'b1;
        if (req[r] && ((mask[r] & lock_map) == '0))
          cand[r] = 1'b1;
      end
    end
  end

  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_vec = '0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      idx = (32'(rr) + i) % NREQ_U;
      if (!gnt_vld && cand[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = RRW'(idx);
      end
    end
    if (gnt_vld)
      gnt_vec[gnt_idx] = 1'b1;
    rr_next = (32'(gnt_idx) == NREQ_U - 1) ? '0 : gnt_idx + 1'b1;
  end

  // lock_map is rebuilt from the set that will be HELD after the edge.
  always_comb begin
    lock_next = '0;
    for (int unsigned r = 0; r < NREQ_U; r++) begin
      if ((state[r] == ST_HELD && !rel[r]) || gnt_vec[r])
        lock_next = lock_next | mask[r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREQ_U; r++) begin
        state[r] <= ST_IDLE;
        mask[r]  <= '0;
      end
      lock_map  <= '0;
      grant     <= '0;
      rr        <= '0;
      stall_cnt <= '0;
    end else begin
      grant    <= gnt_vec;
      lock_map <= lock_next;
      if (gnt_vld)
        rr <= rr_next;
      if (any_wait && !gnt_vld && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      for (int unsigned r = 0; r < NREQ_U; r++) begin
        case (state[r])
          ST_IDLE: if (req[r]) begin
            state[r] <= ST_WAIT;
            mask[r]  <= req_mask[r*NPOS +: NPOS];
          end
          ST_WAIT: begin
            if (gnt_vec[r])
              state[r] <= ST_HELD;
            else if (!req[r])
              state[r] <= ST_IDLE;
          end
          ST_HELD: if (rel[r])
            state[r] <= ST_IDLE;
          default: state[r] <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_path_lock_arbiter.sv
// Directed bench for path_lock_arbiter (NREQ=4, NPOS=8) with hand-computed expectations.
module tb_path_lock_arbiter;

  localparam int NREQ = 4;
  localparam int NPOS = 8;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*NPOS-1:0] req_mask;
  logic [NREQ-1:0]      rel;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      held;
  logic [NPOS-1:0]      lock_map;
  logic [31:0]          stall_cnt;

  int total = 0;
  int bad   = 0;

  path_lock_arbiter #(.NREQ(NREQ), .NPOS(NPOS)) dut (
    .clk(clk), .rst(rst), .req(req), .req_mask(req_mask), .rel(rel),
    .grant(grant), .held(held), .lock_map(lock_map), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mask(input int r, input logic [NPOS-1:0] m);
    req_mask[r*NPOS +: NPOS] = m;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; rel = '0; req_mask = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    total++; if (held !== 4'b0000) begin bad++; $display("FAIL reset_held got=%b exp=0000", held); end
    total++; if (lock_map !== 8'h00) begin bad++; $display("FAIL reset_lock got=%h exp=00", lock_map); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_single_grant();
    do_reset();
    set_mask(0, 8'h07); req = 4'b0001;
    step();
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL single_early got=%b exp=0000", grant); end
    step();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", grant); end
    total++; if (held !== 4'b0001) begin bad++; $display("FAIL single_held got=%b exp=0001", held); end
    total++; if (lock_map !== 8'h07) begin bad++; $display("FAIL single_lock got=%h exp=07", lock_map); end
    req = '0;
    step();
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL single_pulse got=%b exp=0000", grant); end
    total++; if (held !== 4'b0001) begin bad++; $display("FAIL single_keep got=%b exp=0001", held); end
    rel = 4'b0001;
    step();
    rel = '0;
    total++; if (held !== 4'b0000) begin bad++; $display("FAIL single_rel_held got=%b exp=0000", held); end
    total++; if (lock_map !== 8'h00) begin bad++; $display("FAIL single_rel_lock got=%h exp=00", lock_map); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL single_stall got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_conflict();
    do_reset();
    set_mask(0, 8'h07); req = 4'b0001;
    step(); step();
    req = '0;
    set_mask(1, 8'h06); req = 4'b0010;
    step();
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL conf_stall0 got=%0d exp=0", stall_cnt); end
    for (int i = 1; i <= 3; i++) begin
      step();
      total++; if (grant !== 4'b0000) begin bad++; $display("FAIL conf_nogrant got=%b exp=0000", grant); end
      total++; if (stall_cnt !== 32'(i)) begin bad++; $display("FAIL conf_stall got=%0d exp=%0d", stall_cnt, i); end
    end
    rel = 4'b0001;
    step();
    rel = '0;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL conf_relk_grant got=%b exp=0000", grant); end
    total++; if (lock_map !== 8'h00) begin bad++; $display("FAIL conf_relk_lock got=%h exp=00", lock_map); end
    total++; if (stall_cnt !== 32'd4) begin bad++; $display("FAIL conf_relk_stall got=%0d exp=4", stall_cnt); end
    step();
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL conf_grant1 got=%b exp=0010", grant); end
    total++; if (held !== 4'b0010) begin bad++; $display("FAIL conf_held1 got=%b exp=0010", held); end
    total++; if (lock_map !== 8'h06) begin bad++; $display("FAIL conf_lock1 got=%h exp=06", lock_map); end
    total++; if (stall_cnt !== 32'd4) begin bad++; $display("FAIL conf_stall_end got=%0d exp=4", stall_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [NREQ-1:0] exp_g;
    logic [NPOS-1:0] exp_l;
    do_reset();
    set_mask(0, 8'h01); set_mask(1, 8'h02); set_mask(2, 8'h04); set_mask(3, 8'h08);
    req = 4'b1111;
    step();
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL b2b_early got=%b exp=0000", grant); end
    for (int i = 0; i < 4; i++) begin
      step();
      exp_g = 4'b0001 << i;
      exp_l = (8'h01 << (i + 1)) - 8'h01;
      total++; if (grant !== exp_g) begin bad++; $display("FAIL b2b_grant got=%b exp=%b", grant, exp_g); end
      total++; if (lock_map !== exp_l) begin bad++; $display("FAIL b2b_lock got=%h exp=%h", lock_map, exp_l); end
    end
    total++; if (held !== 4'b1111) begin bad++; $display("FAIL b2b_held got=%b exp=1111", held); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL b2b_stall got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] seq [4];
    logic [NREQ-1:0] exp_seq [4];
    int n;
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b0001; exp_seq[3] = 4'b0100;
    n = 0;
    do_reset();
    set_mask(0, 8'h03); set_mask(2, 8'h03);
    req = 4'b0101;
    for (int c = 0; c < 40 && n < 4; c++) begin
      step();
      if (grant !== 4'b0000) begin
        seq[n] = grant;
        n++;
      end
      rel = grant;
    end
    req = '0; rel = '0;
    total++; if (n !== 4) begin bad++; $display("FAIL rr_timeout got=%0d exp=4 grants", n); end
    for (int i = 0; i < n; i++) begin
      total++; if (seq[i] !== exp_seq[i]) begin bad++; $display("FAIL rr_order[%0d] got=%b exp=%b", i, seq[i], exp_seq[i]); end
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    set_mask(1, 8'h10); req = 4'b0010;
    step();
    req = '0;
    step();
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL wd_grant got=%b exp=0000", grant); end
    total++; if (held !== 4'b0000) begin bad++; $display("FAIL wd_held got=%b exp=0000", held); end
    total++; if (stall_cnt !== 32'd1) begin bad++; $display("FAIL wd_stall got=%0d exp=1", stall_cnt); end
    step();
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL wd_late_grant got=%b exp=0000", grant); end
    total++; if (stall_cnt !== 32'd1) begin bad++; $display("FAIL wd_idle_stall got=%0d exp=1", stall_cnt); end
    rel = 4'b1000;
    step();
    rel = '0;
    total++; if (held !== 4'b0000) begin bad++; $display("FAIL idle_rel_held got=%b exp=0000", held); end
    total++; if (lock_map !== 8'h00) begin bad++; $display("FAIL idle_rel_lock got=%h exp=00", lock_map); end
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL idle_rel_grant got=%b exp=0000", grant); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_mask(2, 8'h3C); req = 4'b0100;
    step(); step();
    total++; if (lock_map !== 8'h3C) begin bad++; $display("FAIL ar_setup_lock got=%h exp=3c", lock_map); end
    set_mask(1, 8'h04); req = 4'b0010;
    step(); step();
    set_mask(3, 8'h00); req = 4'b1010;
    step(); step();
    total++; if (grant !== 4'b1000) begin bad++; $display("FAIL ar_zero_mask_grant got=%b exp=1000", grant); end
    total++; if (held !== 4'b1100) begin bad++; $display("FAIL ar_pre_held got=%b exp=1100", held); end
    total++; if (lock_map !== 8'h3C) begin bad++; $display("FAIL ar_pre_lock got=%h exp=3c", lock_map); end
    total++; if (stall_cnt !== 32'd2) begin bad++; $display("FAIL ar_pre_stall got=%0d exp=2", stall_cnt); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (lock_map !== 8'h00) begin bad++; $display("FAIL ar_lock got=%h exp=00", lock_map); end
    total++; if (held !== 4'b0000) begin bad++; $display("FAIL ar_held got=%b exp=0000", held); end
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL ar_grant got=%b exp=0000", grant); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL ar_stall got=%0d exp=0", stall_cnt); end
    req = '0;
    step();
    rst = 1'b0;
    step();
    total++; if (held !== 4'b0000) begin bad++; $display("FAIL ar_after_held got=%b exp=0000", held); end
    total++; if (lock_map !== 8'h00) begin bad++; $display("FAIL ar_after_lock got=%h exp=00", lock_map); end
  endtask

  initial begin
    rst = 1'b1; req = '0; rel = '0; req_mask = '0;
    test_reset();
    test_single_grant();
    test_conflict();
    test_back_to_back();
    test_round_robin();
    test_withdraw();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/path_lock_arbiter.md
PATH_LOCK_ARBITER -- requirements
Module: path_lock_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of solver requesters (1..8).
REQ-002 SHALL have parameter NPOS, default 64, meaning number of lockable path positions.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  NREQ  per-requester lock request, level.
REQ-006 SHALL have port req_mask  input  NREQ*NPOS  flattened; bits [r*NPOS +: NPOS] are the positions requester r wants.
REQ-007 SHALL have port rel  input  NREQ  per-requester release strobe.
REQ-008 SHALL have port grant  output  NREQ  one-cycle grant pulse per requester.
REQ-009 SHALL have port held  output  NREQ  requester currently owns its lock set.
REQ-010 SHALL have port lock_map  output  NPOS  OR of all held masks.
REQ-011 SHALL have port stall_cnt  output  32  count of cycles with waiters but no grant.

Function
REQ-012 SHALL keep, per requester, a state IDLE/WAIT/HELD and a registered NPOS-bit mask.
REQ-013 SHALL, in IDLE with req=1 at an edge, latch that requester's req_mask and enter WAIT.
REQ-014 SHALL, in WAIT with req=0 at an edge, return to IDLE with no grant (withdrawal).
REQ-015 SHALL, at each edge, grant at most one WAIT requester: the first, in round-robin order from pointer rr, whose latched mask ANDed with registered lock_map is zero.
REQ-016 SHALL, on grant to r: set state HELD, OR mask into lock_map, assert grant[r] for exactly the following cycle, and set rr to (r+1) mod NREQ.
REQ-017 SHALL leave rr unchanged in cycles without a grant.
REQ-018 SHALL yield minimum latency: req sampled at edge k, grant high in the cycle after edge k+1.
REQ-019 SHALL treat an all-zero mask as conflict-free (grantable when selected).
REQ-020 SHALL, on rel[r]=1 at an edge while HELD, clear r's mask bits from lock_map and return r to IDLE; rel in IDLE or WAIT is ignored.
REQ-021 SHALL evaluate grants against the pre-edge lock_map, so positions released at edge k are grantable no earlier than edge k+1.
REQ-022 SHALL keep held[r] high exactly while state is HELD; req is ignored while HELD.
REQ-023 SHALL never grant two requesters with overlapping masks simultaneously held; lock_map always equals OR of HELD masks.
REQ-024 SHALL increment stall_cnt at an edge where at least one requester was WAIT and no grant occurred, saturating at 32'hFFFFFFFF.
REQ-025 SHALL allow a requester released at edge k to re-request in IDLE from edge k+1.

Reset
REQ-026 SHALL, while rst=1 (asynchronously), force all states IDLE, masks 0, lock_map 0, grant 0, held 0, rr 0, stall_cnt 0.
REQ-027 SHALL discard all in-flight requests and locks on reset mid-operation; requesters must re-request after rst falls.

Verification
REQ-028 SHALL cover: NREQ=4, r0 req mask 0x7 -> grant[0] pulse 2 cycles after req, lock_map=0x7, held=0001.
REQ-029 SHALL cover: r0 holds 0x7, r1 requests 0x6 -> no grant, stall_cnt +1 per cycle; rel[0] at edge k -> grant[1] after edge k+1, lock_map=0x6.
REQ-030 SHALL cover: r0..r3 request disjoint masks 0x1,0x2,0x4,0x8 same cycle -> grants in order 0,1,2,3 on consecutive cycles, lock_map=0xF.
REQ-031 SHALL cover round-robin fairness: r0 and r2 repeatedly request identical mask 0x3 with immediate release -> grants alternate 0,2,0,2.
REQ-032 SHALL cover: r1 WAIT then req dropped -> IDLE, no grant, held[1]=0; rel[3] while IDLE -> no change.
REQ-033 SHALL cover: rst asserted mid-cycle with lock_map=0x3C -> lock_map, held, grant, stall_cnt all 0 immediately, before next clk edge.
